// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: config/reset sequencer and frame-capture FIFO around RxUnit; `UART_RX_DROP_ERR_EN drops errored frames.
// Latency: a rx_done rising edge in RUN is visible at m_valid one cycle later.
// Backpressure: m_ready stalls pops; a push into a full FIFO without a pop is discarded and sets sticky overrun.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RST_CYCLES = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            cfg_wr,
  input  logic [1:0]                      cfg_baud,
  input  logic [1:0]                      cfg_parity,
  output logic                            cfg_busy,
  output logic                            rx_reset_n,
  output logic [1:0]                      rx_baud,
  output logic [1:0]                      rx_parity,
  input  logic                            rx_active,
  input  logic                            rx_done,
  input  logic [2:0]                      rx_error,
  input  logic [DATA_BITS-1:0]            rx_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_BITS-1:0]            m_data,
  output logic [2:0]                      m_err,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overrun,
  output logic [ERR_CNT_W-1:0]            err_cnt,
  input  logic                            clr_stat
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int EW = DATA_BITS + 3;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {ST_OFF, ST_APPLY, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic [RW-1:0]        rst_cnt_q, rst_cnt_d;
  logic                 rx_reset_n_q, rx_reset_n_d;
  logic [1:0]           rx_baud_q, rx_baud_d;
  logic [1:0]           rx_parity_q, rx_parity_d;
  logic [1:0]           shadow_baud_q, shadow_baud_d;
  logic [1:0]           shadow_parity_q, shadow_parity_d;
  logic                 pending_q, pending_d;
  logic                 cfg_busy_q, cfg_busy_d;
  logic                 done_q, done_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [EW-1:0]        mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic enter_apply;
  logic capture;
  logic frame_err;
  logic push;
  logic push_ok;
  logic pop;
  logic full;

  always_comb begin
    state_d         = state_q;
    rst_cnt_d       = rst_cnt_q;
    rx_baud_d       = rx_baud_q;
    rx_parity_d     = rx_parity_q;
    shadow_baud_d   = shadow_baud_q;
    shadow_parity_d = shadow_parity_q;

    case (state_q)
      ST_OFF:   if (enable) state_d = ST_APPLY;
      ST_APPLY: begin
        if (rst_cnt_q == RST_LAST) state_d = ST_RUN;
        else                       rst_cnt_d = rst_cnt_q + RW'(1);
      end
      ST_RUN:   if (pending_q && !rx_active) state_d = ST_APPLY;
      default:  state_d = ST_OFF;
    endcase
    if (!enable) state_d = ST_OFF;

    enter_apply = (state_d == ST_APPLY) && (state_q != ST_APPLY);
    if (enter_apply) begin
      rst_cnt_d   = '0;
      rx_baud_d   = shadow_baud_q;
      rx_parity_d = shadow_parity_q;
    end

    // A write landing on the APPLY entry cycle must survive the pending clear.
    pending_d = cfg_wr | (pending_q & ~enter_apply);
    if (cfg_wr) begin
      shadow_baud_d   = cfg_baud;
      shadow_parity_d = cfg_parity;
    end

    rx_reset_n_d = (state_d == ST_RUN);
    cfg_busy_d   = pending_d | (state_d == ST_APPLY);
  end

  always_comb begin
    done_d    = rx_done;
    capture   = (state_q == ST_RUN) && rx_done && !done_q;
    frame_err = |rx_error;
`ifdef UART_RX_DROP_ERR_EN
    push      = capture && !frame_err;
`else
    push      = capture;
`endif
    full      = (count_q == FULL_CNT);
    pop       = (count_q != '0) && m_ready;
    push_ok   = push && (!full || pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {rx_error, rx_data};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push_ok) count_d = count_q - CW'(1);

    // New events take precedence over a coincident clear.
    overrun_d = overrun_q;
    if (push && full && !pop) overrun_d = 1'b1;
    else if (clr_stat)        overrun_d = 1'b0;

    err_cnt_d = err_cnt_q;
    if (capture && frame_err) begin
      if (clr_stat)              err_cnt_d = ERR_CNT_W'(1);
      else if (err_cnt_q != '1)  err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end else if (clr_stat) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_OFF;
      rst_cnt_q       <= '0;
      rx_reset_n_q    <= 1'b0;
      rx_baud_q       <= 2'b10;
      rx_parity_q     <= 2'b00;
      shadow_baud_q   <= 2'b10;
      shadow_parity_q <= 2'b00;
      pending_q       <= 1'b0;
      cfg_busy_q      <= 1'b0;
      done_q          <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      overrun_q       <= 1'b0;
      err_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      rst_cnt_q       <= rst_cnt_d;
      rx_reset_n_q    <= rx_reset_n_d;
      rx_baud_q       <= rx_baud_d;
      rx_parity_q     <= rx_parity_d;
      shadow_baud_q   <= shadow_baud_d;
      shadow_parity_q <= shadow_parity_d;
      pending_q       <= pending_d;
      cfg_busy_q      <= cfg_busy_d;
      done_q          <= done_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      overrun_q       <= overrun_d;
      err_cnt_q       <= err_cnt_d;
    end
  end

  assign cfg_busy   = cfg_busy_q;
  assign rx_reset_n = rx_reset_n_q;
  assign rx_baud    = rx_baud_q;
  assign rx_parity  = rx_parity_q;
  assign m_valid    = (count_q != '0);
  assign m_data     = mem_q[rd_ptr_q][DATA_BITS-1:0];
`ifdef UART_RX_DROP_ERR_EN
  assign m_err      = 3'b000;
`else
  assign m_err      = mem_q[rd_ptr_q][EW-1:DATA_BITS];
`endif
  assign fifo_count = count_q;
  assign overrun    = overrun_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_uart_rx_ctrl;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int RST_CYCLES = 4;
  localparam int ERR_CNT_W  = 8;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_RX_DROP_ERR_EN
  localparam bit DROP_ERR = 1'b1;
`else
  localparam bit DROP_ERR = 1'b0;
`endif

  logic                 clock, reset, enable, cfg_wr;
  logic [1:0]           cfg_baud, cfg_parity;
  logic                 cfg_busy, rx_reset_n;
  logic [1:0]           rx_baud, rx_parity;
  logic                 rx_active, rx_done;
  logic [2:0]           rx_error;
  logic [DATA_BITS-1:0] rx_data;
  logic                 m_valid, m_ready;
  logic [DATA_BITS-1:0] m_data;
  logic [2:0]           m_err;
  logic [CW-1:0]        fifo_count;
  logic                 overrun;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 clr_stat;

  uart_rx_ctrl #(
    .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH), .RST_CYCLES(RST_CYCLES), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .cfg_wr(cfg_wr), .cfg_baud(cfg_baud),
    .cfg_parity(cfg_parity), .cfg_busy(cfg_busy), .rx_reset_n(rx_reset_n), .rx_baud(rx_baud),
    .rx_parity(rx_parity), .rx_active(rx_active), .rx_done(rx_done), .rx_error(rx_error),
    .rx_data(rx_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err),
    .fifo_count(fifo_count), .overrun(overrun), .err_cnt(err_cnt), .clr_stat(clr_stat)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: frame queue, sticky overrun, saturating error count.
  logic [10:0] mq[$];
  logic [7:0]  m_errcnt;
  bit          m_ovr;
  bit          mdl_run;
  bit          prev_done;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    logic [10:0] ent;
    bit rise, evt_err, evt_ovr;
    rise    = mdl_run && (rx_done === 1'b1) && !prev_done;
    evt_err = rise && (rx_error != 3'b000);
    evt_ovr = 1'b0;
    if (mq.size() > 0 && m_ready === 1'b1) ent = mq.pop_front();
    if (rise && !(DROP_ERR && evt_err)) begin
      if (mq.size() < FIFO_DEPTH) mq.push_back({rx_error, rx_data});
      else                        evt_ovr = 1'b1;
    end
    if (evt_err)       m_errcnt = clr_stat ? 8'd1 : ((m_errcnt == 8'hFF) ? 8'hFF : m_errcnt + 8'd1);
    else if (clr_stat) m_errcnt = 8'd0;
    if (evt_ovr)       m_ovr = 1'b1;
    else if (clr_stat) m_ovr = 1'b0;
    prev_done = rx_done;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    n_tests++; if (rx_reset_n !== 1'b0) begin n_fail++; $display("FAIL rst_rx_reset_n: got %b want 0", rx_reset_n); end
    n_tests++; if (rx_baud !== 2'b10) begin n_fail++; $display("FAIL rst_rx_baud: got %b want 10", rx_baud); end
    n_tests++; if (rx_parity !== 2'b00) begin n_fail++; $display("FAIL rst_rx_parity: got %b want 00", rx_parity); end
    n_tests++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_busy: got %b want 0", cfg_busy); end
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    n_tests++; if (fifo_count !== '0) begin n_fail++; $display("FAIL rst_fifo_count: got %0d want 0", fifo_count); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    n_tests++; if (err_cnt !== '0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
    n_tests++; if (m_data !== '0 || m_err !== 3'b000) begin n_fail++; $display("FAIL rst_head: got %h/%b want 00/000", m_data, m_err); end
    reset = 1'b0;
  endtask

  task automatic test_apply();
    int  lows;
    bit  busy_ok;
    cfg_baud = 2'b10; cfg_parity = 2'b01; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    n_tests++; if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL apply_pending_busy: got %b want 1", cfg_busy); end
    n_tests++; if (rx_parity !== 2'b00) begin n_fail++; $display("FAIL apply_off_parity: got %b want 00", rx_parity); end
    enable = 1'b1;
    tick();
    n_tests++; if (rx_baud !== 2'b10 || rx_parity !== 2'b01) begin n_fail++; $display("FAIL apply_cfg: got %b/%b want 10/01", rx_baud, rx_parity); end
    lows = 0; busy_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rx_reset_n !== 1'b0) break;
      lows++;
      if (cfg_busy !== 1'b1) busy_ok = 1'b0;
      tick();
    end
    n_tests++; if (lows != RST_CYCLES) begin n_fail++; $display("FAIL apply_low_cycles: got %0d want %0d", lows, RST_CYCLES); end
    n_tests++; if (rx_reset_n !== 1'b1) begin n_fail++; $display("FAIL apply_run_timeout: got %b want 1", rx_reset_n); end
    n_tests++; if (!busy_ok || cfg_busy !== 1'b0) begin n_fail++; $display("FAIL apply_busy: got %b/%b want 1/0", busy_ok, cfg_busy); end
    mdl_run = 1'b1;
  endtask

  task automatic test_single_frame();
    m_ready = 1'b0; rx_error = 3'b000; rx_data = 8'hA5; rx_done = 1'b1;
    tick();
    n_tests++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin n_fail++; $display("FAIL single_head: got %b/%h want 1/a5", m_valid, m_data); end
    n_tests++; if (fifo_count !== 1) begin n_fail++; $display("FAIL single_count1: got %0d want 1", fifo_count); end
    tick(); tick();
    rx_done = 1'b0;
    tick();
    n_tests++; if (fifo_count !== 1 || mq.size() != 1) begin n_fail++; $display("FAIL single_once: got %0d want 1", fifo_count); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_tests++; if (m_valid !== 1'b0 || fifo_count !== 0) begin n_fail++; $display("FAIL single_pop: got %b/%0d want 0/0", m_valid, fifo_count); end
  endtask

  task automatic test_overrun();
    m_ready = 1'b0; rx_error = 3'b000;
    for (int v = 1; v <= 5; v++) begin
      rx_data = 8'(v); rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      tick();
    end
    n_tests++; if (fifo_count !== 4) begin n_fail++; $display("FAIL ovr_count: got %0d want 4", fifo_count); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    m_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n_tests++; if (m_valid !== 1'b1 || m_data !== 8'(k)) begin n_fail++; $display("FAIL ovr_pop_order: got %b/%h want 1/%h", m_valid, m_data, 8'(k)); end
      tick();
    end
    m_ready = 1'b0;
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drained: got %b want 0", m_valid); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
  endtask

  task automatic test_error_frame();
    logic       exp_vld;
    logic [2:0] exp_err;
    exp_vld = DROP_ERR ? 1'b0 : 1'b1;
    exp_err = DROP_ERR ? 3'b000 : 3'b001;
    rx_data = 8'hAA; rx_error = 3'b001; rx_done = 1'b1;
    tick();
    rx_done = 1'b0; rx_error = 3'b000;
    n_tests++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL err_cnt_one: got %0d want 1", err_cnt); end
    n_tests++; if (m_valid !== exp_vld) begin n_fail++; $display("FAIL err_push: got %b want %b", m_valid, exp_vld); end
    n_tests++; if (m_err !== exp_err) begin n_fail++; $display("FAIL err_flags: got %b want %b", m_err, exp_err); end
    n_tests++; if (fifo_count !== CW'(mq.size())) begin n_fail++; $display("FAIL err_count: got %0d want %0d", fifo_count, mq.size()); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_cfg_during_frame();
    int lows;
    rx_active = 1'b1;
    cfg_baud = 2'b11; cfg_parity = 2'b01; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (rx_baud !== 2'b10 || cfg_busy !== 1'b1 || rx_reset_n !== 1'b1) begin n_fail++; $display("FAIL cfg_deferred: got baud=%b busy=%b rstn=%b want 10/1/1", rx_baud, cfg_busy, rx_reset_n); end
      tick();
    end
    rx_data = 8'h3C; rx_error = 3'b000; rx_done = 1'b1;
    tick();
    n_tests++; if (fifo_count !== 1 || rx_baud !== 2'b10) begin n_fail++; $display("FAIL cfg_frame_capture: got cnt=%0d baud=%b want 1/10", fifo_count, rx_baud); end
    rx_done = 1'b0; rx_active = 1'b0;
    tick();
    mdl_run = 1'b0;
    n_tests++; if (rx_baud !== 2'b11 || rx_reset_n !== 1'b0 || cfg_busy !== 1'b1) begin n_fail++; $display("FAIL cfg_applied: got baud=%b rstn=%b busy=%b want 11/0/1", rx_baud, rx_reset_n, cfg_busy); end
    n_tests++; if (m_data !== 8'h3C) begin n_fail++; $display("FAIL cfg_frame_kept: got %h want 3c", m_data); end
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (rx_reset_n !== 1'b0) break;
      lows++;
      tick();
    end
    n_tests++; if (lows != RST_CYCLES || cfg_busy !== 1'b0) begin n_fail++; $display("FAIL cfg_reapply: got lows=%0d busy=%b want %0d/0", lows, cfg_busy, RST_CYCLES); end
    mdl_run = 1'b1;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [10:0] head;
    for (int c = 0; c < 400; c++) begin
      rx_done  = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      rx_error = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b000;
      m_ready  = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr_stat = ($urandom_range(0, 31) == 0);
      tick();
      n_tests++; if (m_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, m_valid, mq.size() != 0); end
      n_tests++; if (fifo_count !== CW'(mq.size())) begin n_fail++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, fifo_count, mq.size()); end
      if (mq.size() != 0) begin
        head = mq[0];
        n_tests++; if (m_data !== head[7:0] || m_err !== head[10:8]) begin n_fail++; $display("FAIL rnd_head c=%0d: got %h/%b want %h/%b", c, m_data, m_err, head[7:0], head[10:8]); end
      end
      n_tests++; if (overrun !== m_ovr) begin n_fail++; $display("FAIL rnd_overrun c=%0d: got %b want %b", c, overrun, m_ovr); end
      n_tests++; if (err_cnt !== m_errcnt) begin n_fail++; $display("FAIL rnd_err_cnt c=%0d: got %0d want %0d", c, err_cnt, m_errcnt); end
    end
    rx_done = 1'b0; rx_error = 3'b000; clr_stat = 1'b0; m_ready = 1'b1;
    repeat (6) tick();
    m_ready = 1'b0;
  endtask

  task automatic test_saturate();
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    n_tests++; if (err_cnt !== 8'd0 || overrun !== 1'b0) begin n_fail++; $display("FAIL sat_clear: got %0d/%b want 0/0", err_cnt, overrun); end
    m_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      rx_error = 3'b100; rx_data = 8'($urandom); rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      tick();
    end
    n_tests++; if (err_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_value: got %0d want 255", err_cnt); end
    rx_error = 3'b010; rx_done = 1'b1; clr_stat = 1'b1;
    tick();
    rx_done = 1'b0; rx_error = 3'b000; clr_stat = 1'b0;
    n_tests++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL clr_vs_err: got %0d want 1", err_cnt); end
    repeat (3) tick();
    m_ready = 1'b0;
    n_tests++; if (fifo_count !== 0) begin n_fail++; $display("FAIL sat_drained: got %0d want 0", fifo_count); end
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'(8'h40 + i); rx_done = 1'b1; clr_stat = (i == 4);
      tick();
      rx_done = 1'b0; clr_stat = 1'b0;
      tick();
    end
    n_tests++; if (overrun !== 1'b1 || fifo_count !== 4) begin n_fail++; $display("FAIL clr_vs_ovr: got %b/%0d want 1/4", overrun, fifo_count); end
    clr_stat = 1'b1; m_ready = 1'b1;
    tick();
    clr_stat = 1'b0;
    repeat (4) tick();
    m_ready = 1'b0;
  endtask

  task automatic test_enable_off_reset();
    m_ready = 1'b1; rx_error = 3'b100; rx_data = 8'h99; rx_done = 1'b1;
    tick();
    rx_done = 1'b0; rx_error = 3'b000;
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rx_data = (i == 0) ? 8'h11 : 8'h22; rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      tick();
    end
    n_tests++; if (fifo_count !== 2 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL off_setup: got %0d/%0d want 2/1", fifo_count, err_cnt); end
    rx_active = 1'b1; enable = 1'b0;
    tick();
    mdl_run = 1'b0;
    n_tests++; if (rx_reset_n !== 1'b0 || fifo_count !== 2 || m_data !== 8'h11) begin n_fail++; $display("FAIL off_hold: got rstn=%b cnt=%0d head=%h want 0/2/11", rx_reset_n, fifo_count, m_data); end
    rx_data = 8'h77; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
    n_tests++; if (fifo_count !== CW'(mq.size()) || fifo_count !== 2) begin n_fail++; $display("FAIL off_ignore_done: got %0d want 2", fifo_count); end
    rx_active = 1'b0; enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rx_reset_n === 1'b1) break;
      tick();
    end
    n_tests++; if (rx_reset_n !== 1'b1 || rx_baud !== 2'b11) begin n_fail++; $display("FAIL off_rerun: got rstn=%b baud=%b want 1/11", rx_reset_n, rx_baud); end
    #2;
    reset = 1'b1;
    #1;
    n_tests++; if (rx_reset_n !== 1'b0) begin n_fail++; $display("FAIL async_rx_reset_n: got %b want 0", rx_reset_n); end
    n_tests++; if (fifo_count !== 0 || m_valid !== 1'b0) begin n_fail++; $display("FAIL async_fifo: got %0d/%b want 0/0", fifo_count, m_valid); end
    n_tests++; if (err_cnt !== 0 || overrun !== 1'b0) begin n_fail++; $display("FAIL async_stats: got %0d/%b want 0/0", err_cnt, overrun); end
    n_tests++; if (rx_baud !== 2'b10 || rx_parity !== 2'b00 || cfg_busy !== 1'b0) begin n_fail++; $display("FAIL async_cfg: got %b/%b/%b want 10/00/0", rx_baud, rx_parity, cfg_busy); end
    enable = 1'b0;
    mq.delete(); m_errcnt = 8'd0; m_ovr = 1'b0; mdl_run = 1'b0; prev_done = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_wr = 1'b0; cfg_baud = 2'b00; cfg_parity = 2'b00;
    rx_active = 1'b0; rx_done = 1'b0; rx_error = 3'b000; rx_data = '0;
    m_ready = 1'b0; clr_stat = 1'b0;
    m_errcnt = 8'd0; m_ovr = 1'b0; mdl_run = 1'b0; prev_done = 1'b0;
    test_reset();
    test_apply();
    test_single_frame();
    test_overrun();
    test_error_frame();
    test_cfg_during_frame();
    test_random();
    test_saturate();
    test_enable_off_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
